// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: FIFO-buffered byte sequencer between the CPU UART data register and the serial emitter.
// Optional feature macro UART_TX_CRLF_EN: a 8'h0D is emitted ahead of every 8'h0A byte.
module uart_tx_ctrl #(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [7:0]              wr_data,
  input  logic                    flush,
  input  logic                    clr_ovr,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    busy,
  output logic                    overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

`ifdef UART_TX_CRLF_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [7:0]      head;
  logic            xfer;
  logic            pop;
  logic            push;
  logic            load_cr;
  logic            lf_hit;
  logic            ovr_set;

  assign head  = mem[rd_ptr];
  assign xfer  = tx_valid && tx_ready;
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign busy  = !empty || tx_valid || !tx_ready;

`ifdef UART_TX_CRLF_EN
  assign lf_hit = (head == 8'h0A);
`else
  assign lf_hit = 1'b0;
`endif

  // Pop happens when the head moves into the holding register; an LF head first parks in CR without popping.
  always_comb begin
    pop     = 1'b0;
    load_cr = 1'b0;
    if (!flush) begin
      case (state)
        IDLE: if (!empty) begin
          load_cr = lf_hit;
          pop     = !lf_hit;
        end
        SEND: if (xfer && !empty) begin
          load_cr = lf_hit;
          pop     = !lf_hit;
        end
`ifdef UART_TX_CRLF_EN
        CR: pop = xfer;
`endif
        default: ;
      endcase
    end
  end

  assign push    = wr_en && !flush && (!full || pop);
  assign ovr_set = wr_en && !flush && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
    end else if (flush) begin
      state    <= IDLE;
      tx_valid <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          tx_valid <= 1'b1;
`ifdef UART_TX_CRLF_EN
          if (load_cr) begin
            tx_data <= 8'h0D;
            state   <= CR;
          end else begin
            tx_data <= head;
            state   <= SEND;
          end
`else
          tx_data <= head;
          state   <= SEND;
`endif
        end
        SEND: if (xfer) begin
          if (!empty) begin
`ifdef UART_TX_CRLF_EN
            if (load_cr) begin
              tx_data <= 8'h0D;
              state   <= CR;
            end else begin
              tx_data <= head;
            end
`else
            tx_data <= head;
`endif
          end else begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
`ifdef UART_TX_CRLF_EN
        CR: if (xfer) begin
          tx_data <= 8'h0A;
          state   <= SEND;
        end
`endif
        default: begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // Sticky drop flag: a same-cycle drop beats clr_ovr, and flush leaves it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     overrun <= 1'b0;
    else if (ovr_set) overrun <= 1'b1;
    else if (clr_ovr) overrun <= 1'b0;
  end

endmodule
